// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first,
// one full-subtractor cell with a registered borrow and start/busy/done handshake.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ov
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             br_q;
  logic             bmsb_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] dw_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;

  logic             x;
  logic             y;
  logic             d;
  logic             br_d;
  logic [WIDTH-1:0] dw_d;
  logic             last;

  always_comb begin
    x    = a_q[0];
    y    = b_q[0];
    d    = x ^ y ^ br_q;
    br_d = (~x & y) | (~x & br_q) | (y & br_q);
    dw_d = {d, dw_q[WIDTH-1:1]};
    last = (cnt_q == CW'(WIDTH - 1));
  end

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      bmsb_q  <= 1'b0;
      cnt_q   <= '0;
      dw_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= SHIFT;
            a_q     <= a;
            b_q     <= b;
            br_q    <= bin;
            cnt_q   <= '0;
            dw_q    <= '0;
            busy_q  <= 1'b1;
          end
        end
        SHIFT: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          br_q  <= br_d;
          dw_q  <= dw_d;
          cnt_q <= cnt_q + CW'(1);
          // Last step: borrow into the MSB feeds the signed-overflow flag.
          if (last) begin
            state_q <= DONE;
            bmsb_q  <= br_q;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            diff_q  <= dw_d;
            bout_q  <= br_d;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
  assign ov   = bout_q ^ bmsb_q;

endmodule
